// File: rtl/fmc_la_pkg.sv
// rtl/fmc_la_pkg.sv - shared mode/state encodings and PRBS7 helper for the FMC LA sequencer
package fmc_la_pkg;

    // Pattern select encodings, shared with software register maps.
    typedef enum logic [1:0] {
        MODE_WALK  = 2'd0,
        MODE_COUNT = 2'd1,
        MODE_PRBS  = 2'd2,
        MODE_RSVD  = 2'd3
    } la_mode_e;

    // Sequencer FSM state encoding.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } la_state_e;

    localparam logic [6:0] PRBS7_SEED = 7'h7F;

    // One step of the x^7+x^6+1 Fibonacci LFSR; the new bit lands in bit 0
    // and is also the stream output bit.
    function automatic logic [6:0] prbs7_next(input logic [6:0] s);
        return {s[5:0], s[6] ^ s[5]};
    endfunction

endpackage

// File: rtl/fmc_la_patgen.sv
// rtl/fmc_la_patgen.sv - LA lane pattern generator (walking-one, counter, PRBS7 shift)
module fmc_la_patgen
    import fmc_la_pkg::*;
#(
    parameter int NPAIR = 34
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       mode_i,
    input  logic             seed_i,
    input  logic             adv_i,
    input  logic             clr_i,
    output logic [NPAIR-1:0] la_p_o,
    output logic [NPAIR-1:0] la_n_o
);

    logic [6:0]       lfsr_q, lfsr_d;
    logic [NPAIR-1:0] pat_q, pat_d;
    logic [NPAIR-1:0] patn_q, patn_d;

    // Next pattern: seed produces step 0 directly so it appears the cycle after LOAD.
    always_comb begin
        lfsr_d = lfsr_q;
        pat_d  = pat_q;
        patn_d = patn_q;
        if (clr_i) begin
            pat_d  = '0;
            patn_d = '0;
        end else if (seed_i) begin
            // PRBS step 0 already consumes one LFSR advance from the seed.
            lfsr_d = prbs7_next(PRBS7_SEED);
            case (la_mode_e'(mode_i))
                MODE_WALK:  pat_d = NPAIR'(1);
                MODE_COUNT: pat_d = '0;
                MODE_PRBS:  pat_d = NPAIR'(lfsr_d[0]);
                default:    pat_d = '0;
            endcase
            patn_d = ~pat_d;
        end else if (adv_i) begin
            case (la_mode_e'(mode_i))
                MODE_WALK:  pat_d = {pat_q[NPAIR-2:0], pat_q[NPAIR-1]};
                MODE_COUNT: pat_d = pat_q + NPAIR'(1);
                MODE_PRBS: begin
                    lfsr_d = prbs7_next(lfsr_q);
                    pat_d  = {pat_q[NPAIR-2:0], lfsr_d[0]};
                end
                default:    pat_d = pat_q;
            endcase
            patn_d = ~pat_d;
        end
    end

    // Pattern, complement and LFSR registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q <= '0;
            pat_q  <= '0;
            patn_q <= '0;
        end else begin
            lfsr_q <= lfsr_d;
            pat_q  <= pat_d;
            patn_q <= patn_d;
        end
    end

    assign la_p_o = pat_q;
    assign la_n_o = patn_q;

endmodule

// File: rtl/fmc_la_seq.sv
// rtl/fmc_la_seq.sv - FMC LA pair test-pattern sequencer (FSM, dwell and step counters)
module fmc_la_seq
    import fmc_la_pkg::*;
#(
    parameter int NPAIR   = 34,
    parameter int DWELL_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic [1:0]         mode,
    input  logic [DWELL_W-1:0] dwell,
    input  logic [15:0]        nsteps,
    output logic [NPAIR-1:0]   la_p,
    output logic [NPAIR-1:0]   la_n,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic [15:0]        step_cnt
);

    la_state_e          state_q, state_d;
    logic [1:0]         mode_q;
    logic [DWELL_W-1:0] dwell_q;
    logic [DWELL_W-1:0] dcnt_q, dcnt_d;
    logic [15:0]        nsteps_q;
    logic [15:0]        step_q, step_d;
    logic               busy_q, done_q, err_q;
    logic               accept, reject, expire, last_step;
    logic               seed, adv, clr;

    // abort outranks start in IDLE; mode 3 is refused with an err pulse.
    assign accept    = (state_q == ST_IDLE) && start && !abort && (mode != MODE_RSVD);
    assign reject    = (state_q == ST_IDLE) && start && !abort && (mode == MODE_RSVD);
    assign expire    = (dcnt_q == dwell_q);
    assign last_step = (step_q == nsteps_q - 16'd1);

    // FSM next-state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept) state_d = ST_LOAD;
            ST_LOAD: begin
                if (abort)                 state_d = ST_IDLE;
                else if (nsteps_q == '0)   state_d = ST_DONE;
                else                       state_d = ST_RUN;
            end
            ST_RUN: begin
                if (abort)                      state_d = ST_IDLE;
                else if (expire && last_step)   state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Dwell/step counters and pattern strobes; counting stops once RUN is left.
    always_comb begin
        dcnt_d = dcnt_q;
        step_d = step_q;
        adv    = 1'b0;
        if (state_q == ST_LOAD) begin
            dcnt_d = '0;
            step_d = '0;
        end else if (state_q == ST_RUN && state_d == ST_RUN) begin
            if (expire) begin
                dcnt_d = '0;
                step_d = step_q + 16'd1;
                adv    = 1'b1;
            end else begin
                dcnt_d = dcnt_q + DWELL_W'(1);
            end
        end
        seed = (state_q == ST_LOAD) && (state_d == ST_RUN);
        clr  = (state_d != ST_RUN);
    end

    // State, latched parameters, counters and registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            mode_q   <= '0;
            dwell_q  <= '0;
            nsteps_q <= '0;
            dcnt_q   <= '0;
            step_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                mode_q   <= mode;
                dwell_q  <= dwell;
                nsteps_q <= nsteps;
            end
            dcnt_q <= dcnt_d;
            step_q <= step_d;
            busy_q <= (state_d != ST_IDLE);
            done_q <= (state_d == ST_DONE);
            err_q  <= reject;
        end
    end

    fmc_la_patgen #(
        .NPAIR (NPAIR)
    ) u_patgen (
        .clk    (clk),
        .rst    (rst),
        .mode_i (mode_q),
        .seed_i (seed),
        .adv_i  (adv),
        .clr_i  (clr),
        .la_p_o (la_p),
        .la_n_o (la_n)
    );

    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;
    assign step_cnt = step_q;

endmodule

// File: tb/tb_fmc_la_seq.sv
// tb/tb_fmc_la_seq.sv - self-checking bench for fmc_la_seq
module tb_fmc_la_seq;

    localparam int NPAIR = 34;
    localparam int DW    = 4;

    logic             clk = 1'b0;
    logic             rst, start, abort;
    logic [1:0]       mode;
    logic [DW-1:0]    dwell;
    logic [15:0]      nsteps;
    logic [NPAIR-1:0] la_p, la_n;
    logic             busy, done, err;
    logic [15:0]      step_cnt;

    int errors = 0;
    int checks = 0;

    fmc_la_seq #(.NPAIR(NPAIR), .DWELL_W(DW)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .abort    (abort),
        .mode     (mode),
        .dwell    (dwell),
        .nsteps   (nsteps),
        .la_p     (la_p),
        .la_n     (la_n),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .step_cnt (step_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected lane pattern for step k, straight from the pattern rules.
    function automatic logic [NPAIR-1:0] exp_pat(input int m, input int k);
        logic [NPAIR-1:0] r;
        bit               hist [0:511];
        r = '0;
        if (m == 0) begin
            r = NPAIR'(1) << (k % NPAIR);
        end else if (m == 1) begin
            r = NPAIR'(k);
        end else begin
            // PRBS7 stream: s[n] = s[n-7] ^ s[n-6], seven ones of history from the seed.
            for (int i = 0; i < 7; i++) hist[i] = 1'b1;
            for (int n = 0; n <= k; n++) hist[n+7] = hist[n] ^ hist[n+1];
            for (int j = 0; j <= k; j++)
                if (k - j < NPAIR) r[k-j] = hist[j+7];
        end
        return r;
    endfunction

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; abort = 1'b0; mode = '0; dwell = '0; nsteps = '0;
        tick(); tick();
        checks++;
        if (la_p !== '0 || la_n !== '0 || busy !== 1'b0 || done !== 1'b0 || err !== 1'b0 || step_cnt !== '0) begin
            errors++;
            $display("FAIL reset: la_p=%h la_n=%h busy=%b done=%b err=%b step=%0d, want all zero", la_p, la_n, busy, done, err, step_cnt);
        end
        rst = 1'b0;
        tick();
    endtask

    // Full sequence, checked every cycle; inputs are scrambled while busy and
    // an optional stray start is injected during RUN.
    task automatic test_sequence(input string name, input int m, input int dw, input int ns, input bit poke);
        logic [NPAIR-1:0] ep;
        mode = m[1:0]; dwell = dw[DW-1:0]; nsteps = ns[15:0]; start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || la_p !== '0 || done !== 1'b0) begin
            errors++;
            $display("FAIL %s load: busy=%b la_p=%h done=%b, want busy=1 la_p=0 done=0", name, busy, la_p, done);
        end
        for (int k = 0; k < ns; k++) begin
            for (int c = 0; c <= dw; c++) begin
                tick();
                ep     = exp_pat(m, k);
                start  = 1'b0;
                mode   = 2'($urandom);
                dwell  = DW'($urandom);
                nsteps = 16'($urandom);
                if (poke && k == 1 && c == 0) start = 1'b1;
                checks++;
                if (la_p !== ep) begin
                    errors++;
                    $display("FAIL %s la_p step %0d cyc %0d: got %h want %h", name, k, c, la_p, ep);
                end
                checks++;
                if (la_n !== ~ep) begin
                    errors++;
                    $display("FAIL %s la_n step %0d cyc %0d: got %h want %h", name, k, c, la_n, ~ep);
                end
                checks++;
                if (step_cnt !== 16'(k)) begin
                    errors++;
                    $display("FAIL %s step_cnt cyc %0d: got %0d want %0d", name, c, step_cnt, k);
                end
                checks++;
                if (busy !== 1'b1 || done !== 1'b0 || err !== 1'b0) begin
                    errors++;
                    $display("FAIL %s status step %0d: busy=%b done=%b err=%b want 1/0/0", name, k, busy, done, err);
                end
            end
        end
        tick();
        start = 1'b0;
        checks++;
        if (done !== 1'b1 || busy !== 1'b1 || la_p !== '0 || la_n !== '0) begin
            errors++;
            $display("FAIL %s done cycle: done=%b busy=%b la_p=%h la_n=%h want 1/1/0/0", name, done, busy, la_p, la_n);
        end
        tick();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || la_p !== '0) begin
            errors++;
            $display("FAIL %s idle after: done=%b busy=%b la_p=%h want 0/0/0", name, done, busy, la_p);
        end
    endtask

    task automatic test_mode3();
        mode = 2'd3; dwell = '0; nsteps = 16'd4; start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (err !== 1'b1 || busy !== 1'b0 || la_p !== '0 || la_n !== '0) begin
            errors++;
            $display("FAIL mode3 pulse: err=%b busy=%b la_p=%h la_n=%h want 1/0/0/0", err, busy, la_p, la_n);
        end
        tick();
        checks++;
        if (err !== 1'b0 || busy !== 1'b0 || la_p !== '0) begin
            errors++;
            $display("FAIL mode3 after: err=%b busy=%b la_p=%h want 0/0/0", err, busy, la_p);
        end
    endtask

    task automatic test_abort_start_idle();
        for (int m = 1; m <= 3; m += 2) begin
            mode = m[1:0]; dwell = '0; nsteps = 16'd3; start = 1'b1; abort = 1'b1;
            tick();
            start = 1'b0; abort = 1'b0;
            checks++;
            if (busy !== 1'b0 || err !== 1'b0) begin
                errors++;
                $display("FAIL abort_wins mode %0d: busy=%b err=%b want 0/0", m, busy, err);
            end
            tick();
            checks++;
            if (busy !== 1'b0 || la_p !== '0 || done !== 1'b0) begin
                errors++;
                $display("FAIL abort_wins after mode %0d: busy=%b la_p=%h done=%b want 0/0/0", m, busy, la_p, done);
            end
        end
    endtask

    task automatic test_abort_run();
        mode = 2'd1; dwell = DW'(9); nsteps = 16'd100; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (31) tick();
        checks++;
        if (la_p !== NPAIR'(3) || step_cnt !== 16'd3) begin
            errors++;
            $display("FAIL abort pre: la_p=%h step=%0d want 3/3", la_p, step_cnt);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checks++;
        if (la_p !== '0 || la_n !== '0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL abort: la_p=%h la_n=%h busy=%b done=%b want all 0", la_p, la_n, busy, done);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL abort idle %0d: done=%b busy=%b want 0/0", i, done, busy);
            end
        end
        test_sequence("abort_rerun", 1, 0, 4, 1'b0);
    endtask

    task automatic test_nsteps0();
        mode = 2'd0; dwell = DW'(2); nsteps = 16'd0; start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || la_p !== '0 || done !== 1'b0) begin
            errors++;
            $display("FAIL nsteps0 load: busy=%b la_p=%h done=%b want 1/0/0", busy, la_p, done);
        end
        tick();
        checks++;
        if (busy !== 1'b1 || done !== 1'b1 || la_p !== '0 || la_n !== '0) begin
            errors++;
            $display("FAIL nsteps0 done: busy=%b done=%b la_p=%h la_n=%h want 1/1/0/0", busy, done, la_p, la_n);
        end
        tick();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || la_p !== '0) begin
            errors++;
            $display("FAIL nsteps0 idle: busy=%b done=%b la_p=%h want 0/0/0", busy, done, la_p);
        end
    endtask

    task automatic test_rst_mid();
        mode = 2'd0; dwell = DW'(1); nsteps = 16'd20; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        checks++;
        if (la_p !== NPAIR'(4) || busy !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid pre: la_p=%h busy=%b want 4/1", la_p, busy);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (la_p !== '0 || la_n !== '0 || busy !== 1'b0 || done !== 1'b0 || err !== 1'b0 || step_cnt !== '0) begin
            errors++;
            $display("FAIL rst_mid: la_p=%h la_n=%h busy=%b done=%b err=%b step=%0d want all 0", la_p, la_n, busy, done, err, step_cnt);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (done !== 1'b0 || busy !== 1'b0 || la_p !== '0) begin
                errors++;
                $display("FAIL rst_mid idle %0d: done=%b busy=%b la_p=%h want 0/0/0", i, done, busy, la_p);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 6; i++)
            test_sequence("random", int'($urandom_range(0, 2)), int'($urandom_range(0, 3)),
                          int'($urandom_range(1, 12)), 1'b1);
    endtask

    initial begin
        test_reset();
        test_sequence("walk", 0, 2, 36, 1'b0);
        test_sequence("count", 1, 0, 5, 1'b0);
        test_sequence("prbs", 2, 0, 10, 1'b0);
        test_sequence("prbs_long", 2, 1, 40, 1'b1);
        test_sequence("dwell_max", 1, 15, 2, 1'b1);
        test_sequence("walk_busy_start", 0, 1, 6, 1'b1);
        test_mode3();
        test_abort_start_idle();
        test_abort_run();
        test_nsteps0();
        test_rst_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
